mem_stage: RTL

- Memory-access stage of the 16-bit pipeline, directly downstream of the ALU stage.
- Consumes the buffered ALU result as either a data address or a write-back value.
- Performs LOAD/STORE/PUSH/POP against an internal word-addressed data memory that holds a stack pointer.
- Presents a registered write-back bundle to the write-back stage and asserts stall while multi-cycle reads are in flight.

---
 rtl/mem_stage.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: LOAD/STORE/PUSH/POP against a word-addressed data memory
// with an internal stack pointer, and a registered write-back bundle.
module mem_stage #(
  parameter int ADDR_W    = 10,
  parameter int LOAD_WAIT = 2,
  parameter int SP_INIT   = (1 << ADDR_W) - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [2:0]        mem_op,
  input  logic [15:0]       alu_result,
  input  logic [15:0]       store_data,
  input  logic [2:0]        rd_in,
  input  logic              wb_en_in,
  output logic              stall,
  output logic              valid_out,
  output logic [15:0]       wb_data,
  output logic [2:0]        rd_out,
  output logic              wb_en_out,
  output logic [ADDR_W-1:0] sp,
  output logic              stack_err
);

  // Handshake: an op is taken on a rising edge where valid_in=1 and stall=0;
  // while stall=1 upstream holds every input steady and nothing is sampled.

  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_PUSH  = 3'd3;
  localparam logic [2:0] OP_POP   = 3'd4;
  localparam logic [2:0] WAIT_INIT = 3'(LOAD_WAIT);
  localparam int         DEPTH     = 1 << ADDR_W;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              stall_q, stall_d;
  logic              valid_q, valid_d;
  logic [15:0]       wb_data_q, wb_data_d;
  logic [2:0]        rd_q, rd_d;
  logic              wb_en_q, wb_en_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [2:0]        lrd_q, lrd_d;
  logic              lwb_q, lwb_d;

  logic [15:0]       mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [15:0]       mem_wdata;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] acc_raddr;
  logic [ADDR_W-1:0] rd_sel;
  logic [15:0]       mem_rdata;

  assign addr      = alu_result[ADDR_W-1:0];
  assign acc_raddr = (mem_op == OP_POP) ? sp_q + ADDR_W'(1) : addr;
  // In WAIT the read uses the address captured at accept, not the held inputs.
  assign rd_sel    = (state_q == S_WAIT) ? raddr_q : acc_raddr;
  assign mem_rdata = mem_q[rd_sel];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_d   = stall_q;
    valid_d   = 1'b0;
    wb_data_d = wb_data_q;
    rd_d      = rd_q;
    wb_en_d   = wb_en_q;
    sp_d      = sp_q;
    err_d     = err_q;
    raddr_d   = raddr_q;
    lrd_d     = lrd_q;
    lwb_d     = lwb_q;
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = store_data;

    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          case (mem_op)
            OP_STORE: begin
              mem_we  = 1'b1;
              valid_d = 1'b1;
              rd_d    = rd_in;
              wb_en_d = 1'b0;
            end
            OP_PUSH: begin
              mem_we    = 1'b1;
              mem_waddr = sp_q;
              sp_d      = sp_q - ADDR_W'(1);
              if (sp_q == '0) err_d = 1'b1;
              valid_d   = 1'b1;
              rd_d      = rd_in;
              wb_en_d   = 1'b0;
            end
            OP_LOAD, OP_POP: begin
              if (mem_op == OP_POP) begin
                sp_d = sp_q + ADDR_W'(1);
                if (&sp_q) err_d = 1'b1;
              end
              if (LOAD_WAIT == 0) begin
                valid_d   = 1'b1;
                wb_data_d = mem_rdata;
                rd_d      = rd_in;
                wb_en_d   = wb_en_in;
              end else begin
                state_d = S_WAIT;
                stall_d = 1'b1;
                cnt_d   = WAIT_INIT;
                raddr_d = acc_raddr;
                lrd_d   = rd_in;
                lwb_d   = wb_en_in;
              end
            end
            default: begin
              valid_d   = 1'b1;
              wb_data_d = alu_result;
              rd_d      = rd_in;
              wb_en_d   = wb_en_in;
            end
          endcase
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d   = S_IDLE;
          stall_d   = 1'b0;
          valid_d   = 1'b1;
          wb_data_d = mem_rdata;
          rd_d      = lrd_q;
          wb_en_d   = lwb_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        stall_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      stall_q   <= 1'b0;
      valid_q   <= 1'b0;
      wb_data_q <= '0;
      rd_q      <= '0;
      wb_en_q   <= 1'b0;
      sp_q      <= ADDR_W'(SP_INIT);
      err_q     <= 1'b0;
      raddr_q   <= '0;
      lrd_q     <= '0;
      lwb_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stall_q   <= stall_d;
      valid_q   <= valid_d;
      wb_data_q <= wb_data_d;
      rd_q      <= rd_d;
      wb_en_q   <= wb_en_d;
      sp_q      <= sp_d;
      err_q     <= err_d;
      raddr_q   <= raddr_d;
      lrd_q     <= lrd_d;
      lwb_q     <= lwb_d;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign stall     = stall_q;
  assign valid_out = valid_q;
  assign wb_data   = wb_data_q;
  assign rd_out    = rd_q;
  assign wb_en_out = wb_en_q;
  assign sp        = sp_q;
  assign stack_err = err_q;

endmodule
